// File: rtl/mag_cmp_seq_if.sv
// mag_cmp_seq_if: handshake and result bundle for the streamed magnitude
// comparator.
//   master : testbench/driver side. Drives start, a_in, b_in, in_valid.
//   slave  : comparator side. Drives in_ready, busy, done, eq, gt, lt,
//            mismatch_cnt.
// W is the word width. N_WORDS is the number of words per operand.
interface mag_cmp_seq_if #(
  parameter int W       = 8,
  parameter int N_WORDS = 4
);
  localparam int CW = $clog2(N_WORDS + 1);

  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic          lt;
  logic [CW-1:0] mismatch_cnt;

  modport master (
    output start, a_in, b_in, in_valid,
    input  in_ready, busy, done, eq, gt, lt, mismatch_cnt
  );

  modport slave (
    input  start, a_in, b_in, in_valid,
    output in_ready, busy, done, eq, gt, lt, mismatch_cnt
  );
endinterface

// File: rtl/mag_cmp_seq.sv
// mag_cmp_seq: sequential unsigned magnitude comparator for two operands of
// N_WORDS x W bits. Word pairs arrive most-significant first, one pair per
// accepted beat (in_valid && in_ready).
//
// The block reports eq/gt/lt and counts the word positions that differ.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; has priority over every other input
//   bus   - mag_cmp_seq_if.slave
//             inputs : start, a_in, b_in, in_valid
//             outputs: in_ready, busy, done, eq, gt, lt, mismatch_cnt
//
// Flow: IDLE --start--> COMPARE --N_WORDS beats--> DONE (1 cycle) --> IDLE.
// Results hold in IDLE until the next accepted start.
module mag_cmp_seq #(
  parameter int W       = 8,
  parameter int N_WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  mag_cmp_seq_if.slave  bus
);
  localparam int CW = $clog2(N_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  state_t        state_q,   state_d;
  logic [CW-1:0] beat_q,    beat_d;
  logic [CW-1:0] mism_q,    mism_d;
  logic          decided_q, decided_d;
  logic          order_q,   order_d;    // 1: A > B at the deciding word
  logic          eq_q,      eq_d;
  logic          gt_q,      gt_d;
  logic          lt_q,      lt_d;

  logic accept;
  logic diff;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    mism_d    = mism_q;
    decided_d = decided_q;
    order_d   = order_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    accept    = (state_q == S_COMPARE) && bus.in_valid;
    diff      = (bus.a_in != bus.b_in);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_COMPARE;
          beat_d    = '0;
          mism_d    = '0;
          decided_d = 1'b0;
          order_d   = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end
      end
      S_COMPARE: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (diff) mism_d = mism_q + 1'b1;
          // Words arrive MSW first, so the first differing word fixes the
          // order. Later words only feed the mismatch count.
          if (!decided_q && diff) begin
            decided_d = 1'b1;
            order_d   = (bus.a_in > bus.b_in);
          end
          // Results are registered on the last beat so that they are
          // already valid during the DONE cycle.
          if (beat_q == CW'(N_WORDS - 1)) begin
            state_d = S_DONE;
            eq_d    = !decided_d;
            gt_d    = decided_d && order_d;
            lt_d    = decided_d && !order_d;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      mism_q    <= '0;
      decided_q <= 1'b0;
      order_q   <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      mism_q    <= mism_d;
      decided_q <= decided_d;
      order_q   <= order_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  // Handshake and status signals are decoded from the state register only.
  assign bus.in_ready     = (state_q == S_COMPARE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.eq           = eq_q;
  assign bus.gt           = gt_q;
  assign bus.lt           = lt_q;
  assign bus.mismatch_cnt = mism_q;
endmodule
